// File: rtl/mux2_rr_feeder_pkg.sv
// rtl/mux2_rr_feeder_pkg.sv - shared scheduler state encoding for the mux2 feeder
package mux2_rr_feeder_pkg;

    // Bit 1 alone marks SERVE1, so the mux select is a plain state register bit
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SERVE0 = 2'b01,
        ST_SERVE1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mux2_rr_feeder_rr_arb2.sv
// rtl/mux2_rr_feeder_rr_arb2.sv - two-way round-robin scheduler FSM with last-served pointer
module rr_arb2
    import mux2_rr_feeder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       full0,
    input  logic       full1,
    input  logic       out_ready,
    output arb_state_e state,
    output logic [1:0] grant_done
);

    arb_state_e state_nxt;
    logic       last;
    logic       last_nxt;

    // State and last-served pointer; last resets to 1 so slot 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: pick a full slot from IDLE, chain straight to the other slot after a handshake
    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        grant_done = 2'b00;
        case (state)
            ST_IDLE: begin
                if (full0 && full1) begin
                    state_nxt = last ? ST_SERVE0 : ST_SERVE1;
                end else if (full0) begin
                    state_nxt = ST_SERVE0;
                end else if (full1) begin
                    state_nxt = ST_SERVE1;
                end
            end
            ST_SERVE0: begin
                if (out_ready) begin
                    grant_done[0] = 1'b1;
                    last_nxt      = 1'b0;
                    state_nxt     = full1 ? ST_SERVE1 : ST_IDLE;
                end
            end
            ST_SERVE1: begin
                if (out_ready) begin
                    grant_done[1] = 1'b1;
                    last_nxt      = 1'b1;
                    state_nxt     = full0 ? ST_SERVE0 : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mux2_rr_feeder.sv
// rtl/mux2_rr_feeder.sv - two one-word source slots feeding a 2:1 mux under round-robin select
module mux2_rr_feeder
    import mux2_rr_feeder_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in0_valid,
    input  logic [N-1:0] in0_data,
    output logic         in0_ready,
    input  logic         in1_valid,
    input  logic [N-1:0] in1_data,
    output logic         in1_ready,
    output logic [N-1:0] x0,
    output logic [N-1:0] x1,
    output logic         s,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [N-1:0] data0;
    logic [N-1:0] data1;
    logic         full0;
    logic         full1;
    arb_state_e   state;
    logic [1:0]   grant_done;

    assign in0_ready = ~full0 & ~rst;
    assign in1_ready = ~full1 & ~rst;

    // Slot 0: capture when empty, release on its handshake (never both, ready is low while full)
    always_ff @(posedge clk) begin
        if (rst) begin
            full0 <= 1'b0;
            data0 <= '0;
        end else if (in0_valid && in0_ready) begin
            full0 <= 1'b1;
            data0 <= in0_data;
        end else if (grant_done[0]) begin
            full0 <= 1'b0;
        end
    end

    // Slot 1: same policy as slot 0
    always_ff @(posedge clk) begin
        if (rst) begin
            full1 <= 1'b0;
            data1 <= '0;
        end else if (in1_valid && in1_ready) begin
            full1 <= 1'b1;
            data1 <= in1_data;
        end else if (grant_done[1]) begin
            full1 <= 1'b0;
        end
    end

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .full0      (full0),
        .full1      (full1),
        .out_ready  (out_ready),
        .state      (state),
        .grant_done (grant_done)
    );

    assign x0        = data0;
    assign x1        = data1;
    assign s         = state[1];
    assign out_valid = state[1] | state[0];

endmodule
